cmp_share_arbiter: RTL and testbench

CMP_SHARE_ARBITER -- requirements
Module: cmp_share_arbiter

---
 rtl/fp_11_5_pkg.sv | 51 +++++
 rtl/greater_than.sv | 84 ++++++++
 rtl/cmp_share_arbiter.sv | 126 ++++++++++++
 tb/tb_cmp_share_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_11_5_pkg.sv
// fp_11_5_pkg: shared definitions for the 19-bit floating-point format
// (2-bit exception, sign, 5-bit exponent, 11-bit fraction) used by the
// shared comparator and its arbiter.
//   - field positions of the operand word
//   - exception codes
//   - default requester count and comparator latency
//   - fp_mag(): exact magnitude of a normal operand as a fixed-point integer
package fp_11_5_pkg;

    localparam int unsigned FP_W     = 19;
    localparam int unsigned EXC_HI   = 18;
    localparam int unsigned EXC_LO   = 17;
    localparam int unsigned SIGN_BIT = 16;
    localparam int unsigned EXP_HI   = 15;
    localparam int unsigned EXP_LO   = 11;
    localparam int unsigned FRAC_HI  = 10;
    localparam int unsigned FRAC_LO  = 0;
    localparam int unsigned EXP_W    = EXP_HI - EXP_LO + 1;
    localparam int unsigned FRAC_W   = FRAC_HI - FRAC_LO + 1;

    localparam int unsigned DEF_N_REQ   = 4;
    localparam int unsigned DEF_CMP_LAT = 3;

    typedef enum logic [1:0] {
        EXC_ZERO   = 2'b00,
        EXC_NORMAL = 2'b01,
        EXC_INF    = 2'b10,
        EXC_NAN    = 2'b11
    } exc_e;

    // Magnitude in units of 2^(-bias-FRAC_W): {1,frac} << biased exponent.
    // Every normal value is exactly representable in MAG_W bits.
    localparam int unsigned MAG_W = FRAC_W + 1 + (2**EXP_W - 1);

    // Smallest normal magnitude; a same-sign difference below it flushes to zero.
    localparam logic [MAG_W-1:0] MIN_NORM = MAG_W'(1) << FRAC_W;

    // An opposite-sign sum at or above this rounds (nearest-even) to overflow.
    localparam logic [MAG_W:0] OVF_LIM =
        ((MAG_W+1)'(1) << MAG_W) - ((MAG_W+1)'(1) << (MAG_W - FRAC_W - 2));

    function automatic logic [MAG_W-1:0] fp_mag(input logic [FP_W-1:0] x);
        logic [MAG_W-1:0] sig;
        sig = {{(MAG_W-FRAC_W-1){1'b0}}, 1'b1, x[FRAC_HI:FRAC_LO]};
        if (x[EXC_HI:EXC_LO] != EXC_NORMAL) begin
            return '0;
        end
        return sig << x[EXP_HI:EXP_LO];
    endfunction

endpackage

// File: rtl/greater_than.sv
// greater_than: pipelined "A - B is a positive normal number" comparator.
// Operands are sampled on the first rising edge; the result is valid three
// cycles after that sampling edge's cycle began (three register stages).
//   clk, rst  : clock, asynchronous active-high reset
//   a, b      : operands, 19-bit FP words
//   greater   : 1 when A-B is normal with sign 0 (overflow, underflow,
//               zero, infinity and NaN results give 0)
module greater_than
    import fp_11_5_pkg::*;
#(
    parameter int unsigned width = 18
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [width:0] a,
    input  logic [width:0] b,
    output logic           greater
);

    logic [width:0]   a_q;
    logic [width:0]   b_q;
    logic [MAG_W-1:0] mag_a_q;
    logic [MAG_W-1:0] mag_b_q;
    logic             sign_a_q;
    logic             sign_b_q;
    logic             zero_a_q;
    logic             zero_b_q;
    logic             special_q;
    logic             greater_q;
    logic             greater_d;
    logic [MAG_W:0]   sum;
    logic [MAG_W-1:0] diff_ab;
    logic [MAG_W-1:0] diff_ba;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q       <= '0;
            b_q       <= '0;
            mag_a_q   <= '0;
            mag_b_q   <= '0;
            sign_a_q  <= 1'b0;
            sign_b_q  <= 1'b0;
            zero_a_q  <= 1'b1;
            zero_b_q  <= 1'b1;
            special_q <= 1'b0;
            greater_q <= 1'b0;
        end else begin
            a_q       <= a;
            b_q       <= b;
            mag_a_q   <= fp_mag(a_q);
            mag_b_q   <= fp_mag(b_q);
            sign_a_q  <= a_q[SIGN_BIT];
            sign_b_q  <= b_q[SIGN_BIT];
            zero_a_q  <= (a_q[EXC_HI:EXC_LO] == EXC_ZERO);
            zero_b_q  <= (b_q[EXC_HI:EXC_LO] == EXC_ZERO);
            // exception 1x on either side: the difference is inf or NaN
            special_q <= a_q[EXC_HI] | b_q[EXC_HI];
            greater_q <= greater_d;
        end
    end

    always_comb begin
        sum       = {1'b0, mag_a_q} + {1'b0, mag_b_q};
        diff_ab   = mag_a_q - mag_b_q;
        diff_ba   = mag_b_q - mag_a_q;
        greater_d = 1'b0;
        if (special_q || (zero_a_q && zero_b_q)) begin
            greater_d = 1'b0;
        end else if (zero_a_q) begin
            greater_d = sign_b_q;
        end else if (zero_b_q) begin
            greater_d = !sign_a_q;
        end else if (sign_a_q != sign_b_q) begin
            greater_d = !sign_a_q && (sum < OVF_LIM);
        end else if (!sign_a_q) begin
            greater_d = (mag_a_q > mag_b_q) && (diff_ab >= MIN_NORM);
        end else begin
            greater_d = (mag_b_q > mag_a_q) && (diff_ba >= MIN_NORM);
        end
    end

    assign greater = greater_q;

endmodule

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: round-robin sharing of one greater_than comparator
// among N_REQ requesters, one accept per cycle, fixed result latency.
//   clk, rst    : clock, asynchronous active-high reset
//   req_valid   : per-requester request
//   req_ready   : one-hot accept (combinational, round-robin winner)
//   req_a/req_b : packed operands, slice i belongs to requester i
//   res_valid   : one-hot result pulse, 1+CMP_LAT cycles after accept
//   res_greater : comparison result, qualified by res_valid
//   busy        : some accepted request has not produced its result yet
module cmp_share_arbiter
    import fp_11_5_pkg::*;
#(
    parameter int unsigned N_REQ   = DEF_N_REQ,
    parameter int unsigned WIDTH   = 18,
    // must equal the comparator's pipeline latency (3 for greater_than)
    parameter int unsigned CMP_LAT = DEF_CMP_LAT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*(WIDTH+1)-1:0] req_a,
    input  logic [N_REQ*(WIDTH+1)-1:0] req_b,
    output logic [N_REQ-1:0]           res_valid,
    output logic                       res_greater,
    output logic                       busy
);

    localparam int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned DEPTH = 1 + CMP_LAT;

    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  cand;
    logic [ID_W-1:0]  win_id;
    logic             win_found;
    logic             accept;
    logic [WIDTH:0]   iss_a;
    logic [WIDTH:0]   iss_b;
    logic [DEPTH-1:0] tag_v;
    logic [ID_W-1:0]  tag_id [DEPTH];
    logic             cmp_greater;

    // First asserted req_valid at or after the pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = ID_W'((32'(ptr) + k) % N_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign accept = win_found && !rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (win_id == ID_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
        end
    end

    // Bubbles issue zero operands so the comparator sees exception 00.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_a <= '0;
            iss_b <= '0;
        end else if (accept) begin
            iss_a <= req_a[win_id*(WIDTH+1) +: (WIDTH+1)];
            iss_b <= req_b[win_id*(WIDTH+1) +: (WIDTH+1)];
        end else begin
            iss_a <= '0;
            iss_b <= '0;
        end
    end

    // Stage 0 lines up with the issue register, the last stage with the
    // comparator output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_v[0]  <= accept;
            tag_id[0] <= win_id;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    greater_than #(
        .width(WIDTH)
    ) u_cmp (
        .clk     (clk),
        .rst     (rst),
        .a       (iss_a),
        .b       (iss_b),
        .greater (cmp_greater)
    );

    always_comb begin
        res_valid = '0;
        if (tag_v[DEPTH-1]) begin
            res_valid[tag_id[DEPTH-1]] = 1'b1;
        end
    end

    assign res_greater = tag_v[DEPTH-1] & cmp_greater;
    assign busy        = |tag_v;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb_cmp_share_arbiter: directed stimulus with literal checks, plus a
// per-cycle comparison against a behavioural model that evaluates the
// FP rule with real arithmetic and schedules results by cycle number.
module tb_cmp_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 18;
    localparam int LAT = 3;
    localparam int FW  = W + 1;

    localparam logic [18:0] ONE     = 19'h27800;
    localparam logic [18:0] TWO     = 19'h28000;
    localparam logic [18:0] NEG_TWO = 19'h38000;
    localparam logic [18:0] NAN_A   = 19'h67800;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*FW-1:0]   req_a;
    logic [N*FW-1:0]   req_b;
    logic [N-1:0]      res_valid;
    logic              res_greater;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;

    cmp_share_arbiter #(
        .N_REQ   (N),
        .WIDTH   (W),
        .CMP_LAT (LAT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .res_valid   (res_valid),
        .res_greater (res_greater),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [18:0] a, input logic [18:0] b);
        req_a[i*FW +: FW] = a;
        req_b[i*FW +: FW] = b;
    endtask

    // ---------------- behavioural model ----------------
    function automatic real pow2(input int e);
        real r;
        r = 1.0;
        if (e >= 0) begin
            for (int i = 0; i < e; i++) r = r * 2.0;
        end else begin
            for (int i = 0; i < -e; i++) r = r / 2.0;
        end
        return r;
    endfunction

    function automatic real fp_real(input logic [18:0] x);
        real m;
        if (x[18:17] == 2'b00) return 0.0;
        m = (1.0 + real'(x[10:0]) / 2048.0) * pow2(int'(x[15:11]) - 15);
        return x[16] ? -m : m;
    endfunction

    // Positive normal: at least 2^-15 and below the overflow rounding point.
    function automatic bit model_gt(input logic [18:0] a, input logic [18:0] b);
        real d;
        if (a[18] || b[18]) return 1'b0;
        d = fp_real(a) - fp_real(b);
        return (d >= pow2(-15)) && (d < pow2(17) - pow2(4));
    endfunction

    bit sched_v  [64];
    int sched_id [64];
    bit sched_gt [64];
    int mptr = 0;
    int cyc  = 0;

    always @(negedge clk) begin : model_cmp
        logic [N-1:0] exp_ready;
        logic [N-1:0] exp_res;
        bit           exp_gt;
        bit           exp_busy;
        int           win;
        int           slot;
        exp_ready = '0;
        exp_res   = '0;
        exp_gt    = 1'b0;
        exp_busy  = 1'b0;
        win       = -1;
        slot      = cyc % 64;
        if (rst) begin
            for (int i = 0; i < 64; i++) sched_v[i] = 1'b0;
            mptr = 0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (win < 0 && req_valid[(mptr + k) % N]) win = (mptr + k) % N;
            end
            if (win >= 0) exp_ready[win] = 1'b1;
            if (sched_v[slot]) begin
                exp_res[sched_id[slot]] = 1'b1;
                exp_gt = sched_gt[slot];
            end
            for (int k = 0; k <= LAT; k++) begin
                if (sched_v[(cyc + k) % 64]) exp_busy = 1'b1;
            end
        end
        check("model req_ready", req_ready, exp_ready);
        check("model res_valid", res_valid, exp_res);
        check("model res_greater", res_greater, exp_gt);
        check("model busy", busy, exp_busy);
        if (!rst) begin
            sched_v[slot] = 1'b0;
            if (win >= 0) begin
                sched_v [(cyc + 1 + LAT) % 64] = 1'b1;
                sched_id[(cyc + 1 + LAT) % 64] = win;
                sched_gt[(cyc + 1 + LAT) % 64] = model_gt(req_a[win*FW +: FW], req_b[win*FW +: FW]);
                mptr = (win + 1) % N;
            end
        end
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    logic [18:0] tbl_a [14];
    logic [18:0] tbl_b [14];

    initial begin
        tbl_a = '{19'h28000, 19'h00000, 19'h00000, 19'h48000, 19'h27800, 19'h20001, 19'h20800,
                  19'h2FFFF, 19'h2F800, 19'h2F800, 19'h2FFFF, 19'h2FFFF, 19'h37800, 19'h27800};
        tbl_b = '{19'h00000, 19'h37800, 19'h27800, 19'h27800, 19'h58000, 19'h20000, 19'h20000,
                  19'h3FFFF, 19'h3F800, 19'h37800, 19'h39800, 19'h39000, 19'h38000, 19'h27800};

        rst       = 1'b1;
        req_a     = '0;
        req_b     = '0;
        req_valid = 4'b0001;
        set_ops(0, TWO, ONE);
        repeat (3) @(negedge clk);
        check("reset req_ready", req_ready, 0);
        check("reset res_valid", res_valid, 0);
        check("reset res_greater", res_greater, 0);
        check("reset busy", busy, 0);
        tick();
        rst       = 1'b0;
        req_valid = '0;
        tick();

        // single request from requester 2, 2.0 vs 1.0
        set_ops(2, TWO, ONE);
        req_valid = 4'b0100;
        @(negedge clk);
        check("t1 ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        @(negedge clk);
        check("t1 busy", busy, 1);
        repeat (2) @(negedge clk);
        check("t1 early res_valid", res_valid, 0);
        @(negedge clk);
        check("t1 res_valid", res_valid, 4'b0100);
        check("t1 res_greater", res_greater, 1);
        @(negedge clk);
        check("t1 after res_valid", res_valid, 0);
        check("t1 after busy", busy, 0);

        // reset pulse returns the pointer to 0
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // all four requesters at once, equal operands
        for (int i = 0; i < 4; i++) set_ops(i, ONE, ONE);
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2 ready order", req_ready, 32'(1) << i);
            tick();
            req_valid[i] = 1'b0;
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2 res order", res_valid, 32'(1) << i);
            check("t2 res_greater", res_greater, 0);
        end
        tick();

        // requester 1 streaming 8 back-to-back, alternating operands
        for (int k = 0; k < 12; k++) begin
            if (k < 8) begin
                req_valid = 4'b0010;
                if (k % 2 == 0) set_ops(1, TWO, ONE);
                else            set_ops(1, ONE, TWO);
            end else begin
                req_valid = '0;
            end
            @(negedge clk);
            if (k < 8) check("t3 ready", req_ready, 4'b0010);
            if (k >= 4) begin
                check("t3 res_valid", res_valid, 4'b0010);
                check("t3 res_greater", res_greater, (k % 2 == 0) ? 1 : 0);
            end
            tick();
        end
        @(negedge clk);
        check("t3 busy drained", busy, 0);
        tick();

        // wrap-around: 3 wins, then 0 and 3 request
        set_ops(3, TWO, ONE);
        req_valid = 4'b1000;
        @(negedge clk);
        check("t4 ready 3", req_ready, 4'b1000);
        tick();
        set_ops(0, ONE, TWO);
        req_valid = 4'b1001;
        @(negedge clk);
        check("t4 ready 0 first", req_ready, 4'b0001);
        tick();
        req_valid = 4'b1000;
        @(negedge clk);
        check("t4 ready 3 second", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        repeat (6) tick();

        // reset one cycle after three accepts discards them
        for (int i = 0; i < 3; i++) set_ops(i, TWO, ONE);
        req_valid = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5 ready", req_ready, 32'(1) << i);
            tick();
            req_valid[i] = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("t5 rst busy", busy, 0);
        check("t5 rst res_valid", res_valid, 0);
        tick();
        rst = 1'b0;
        set_ops(0, TWO, ONE);
        req_valid = 4'b0001;
        @(negedge clk);
        check("t5 regrant", req_ready, 4'b0001);
        check("t5 no stale res", res_valid, 0);
        tick();
        req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5 no stale res", res_valid, 0);
        end
        @(negedge clk);
        check("t5 res_valid", res_valid, 4'b0001);
        check("t5 res_greater", res_greater, 1);
        tick();

        // NaN vs 1.0 and -2.0 vs 1.0
        set_ops(0, NAN_A, ONE);
        req_valid = 4'b0001;
        @(negedge clk);
        check("t6 ready nan", req_ready, 4'b0001);
        tick();
        set_ops(0, NEG_TWO, ONE);
        @(negedge clk);
        check("t6 ready neg", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        repeat (2) @(negedge clk);
        @(negedge clk);
        check("t6 nan res_valid", res_valid, 4'b0001);
        check("t6 nan res_greater", res_greater, 0);
        @(negedge clk);
        check("t6 neg res_valid", res_valid, 4'b0001);
        check("t6 neg res_greater", res_greater, 0);
        tick();

        // FP boundary table (zero, inf, underflow, overflow rounding)
        for (int k = 0; k < 14; k++) begin
            set_ops(k % 4, tbl_a[k], tbl_b[k]);
            req_valid = '0;
            req_valid[k % 4] = 1'b1;
            tick();
        end
        req_valid = '0;
        repeat (8) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
